// File: rtl/dlx_pkg.sv
// Shared DLX decode definitions: opcodes, field positions, instruction
// classes and the decoded-instruction record with its decode function.
package dlx_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDUI = 6'h09;
  localparam logic [5:0] OP_SUBI  = 6'h0A;
  localparam logic [5:0] OP_SUBUI = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LHI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 26;
  localparam int RS1_MSB  = 25;
  localparam int RS1_LSB  = 21;
  localparam int RS2_MSB  = 20;
  localparam int RS2_LSB  = 16;
  localparam int RD_MSB   = 15;
  localparam int RD_LSB   = 11;
  localparam int FUNC_MSB = 5;
  localparam int IMM16_MSB = 15;
  localparam int IMM26_MSB = 25;

  typedef enum logic [1:0] {
    IT_R   = 2'd0,
    IT_I   = 2'd1,
    IT_J   = 2'd2,
    IT_ILL = 2'd3
  } instr_type_e;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [5:0]  func;
    logic [15:0] imm16;
    logic        imm_zext;
    logic [25:0] imm26;
    instr_type_e itype;
    logic        wr_en;
  } dec_instr_t;

  function automatic dec_instr_t decode_instr(input logic [31:0] instr);
    dec_instr_t d;
    d          = '0;
    d.opcode   = instr[OPC_MSB:OPC_LSB];
    d.rs1      = instr[RS1_MSB:RS1_LSB];
    d.rs2      = instr[RS2_MSB:RS2_LSB];
    d.imm16    = instr[IMM16_MSB:0];
    d.imm26    = instr[IMM26_MSB:0];
    d.itype    = IT_ILL;
    d.rd       = 5'd0;
    d.func     = 6'd0;
    d.wr_en    = 1'b0;
    d.imm_zext = 1'b0;
    case (d.opcode)
      OP_RTYPE: begin
        d.itype = IT_R;
        d.rd    = instr[RD_MSB:RD_LSB];
        d.func  = instr[FUNC_MSB:0];
        d.wr_en = (d.rd != 5'd0);
      end
      OP_J: begin
        d.itype = IT_J;
      end
      OP_JAL: begin
        d.itype = IT_J;
        d.rd    = 5'd31;
        d.wr_en = 1'b1;
      end
      OP_BEQZ, OP_BNEZ, OP_SW: begin
        d.itype = IT_I;
        d.rd    = instr[RS2_MSB:RS2_LSB];
      end
      OP_ADDI, OP_ADDUI, OP_SUBI, OP_SUBUI, OP_ANDI, OP_ORI, OP_XORI, OP_LHI, OP_LW: begin
        d.itype = IT_I;
        d.rd    = instr[RS2_MSB:RS2_LSB];
        d.wr_en = (d.rd != 5'd0);
      end
      default: begin
        d.itype = IT_ILL;
      end
    endcase
    case (d.opcode)
      OP_ADDUI, OP_SUBUI, OP_ANDI, OP_ORI, OP_XORI: d.imm_zext = 1'b1;
      default:                                      d.imm_zext = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dlx_field_decode.sv
// Combinational split of a raw DLX word into the decoded-instruction record.
module dlx_field_decode
  import dlx_pkg::*;
(
  input  logic [31:0] i_instr,
  output dec_instr_t  o_dec
);

  assign o_dec = decode_instr(i_instr);

endmodule

// File: rtl/dlx_ir_decode.sv
// DLX instruction register / decode stage: two-entry skid buffer holding
// pre-decoded instructions, valid/ready on both sides, flush to NOP.
module dlx_ir_decode
  import dlx_pkg::*;
#(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [5:0]  out_opcode,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic [5:0]  out_func,
  output logic [15:0] out_imm16,
  output logic        out_imm_zext,
  output logic [25:0] out_imm26,
  output logic [1:0]  out_type,
  output logic        out_wr_en
);

  if (DEPTH != 2) begin : g_depth_check
    $error("dlx_ir_decode supports DEPTH == 2 only");
  end

  typedef struct packed {
    logic [31:0] pc;
    dec_instr_t  dec;
  } entry_t;

  localparam entry_t NOP_ENTRY = '{pc: 32'h0000_0000, dec: decode_instr(NOP_INSTR)};

  dec_instr_t  w_dec;
  entry_t      w_new;
  entry_t      w_head_nxt;
  entry_t      w_tail_nxt;
  logic [1:0]  w_count_nxt;
  logic        w_push;
  logic        w_pop;

  entry_t      r_head;
  entry_t      r_tail;
  logic [1:0]  r_count;
  logic        r_in_ready;
  logic        r_out_valid;

  dlx_field_decode u_field_decode (
    .i_instr (in_instr),
    .o_dec   (w_dec)
  );

  assign w_new  = '{pc: in_pc, dec: w_dec};
  assign w_push = in_valid && r_in_ready && !flush;
  assign w_pop  = r_out_valid && out_ready;

  // Next buffer state; flush wins over any push or pop in the same cycle.
  always_comb begin
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    if (flush) begin
      w_head_nxt  = NOP_ENTRY;
      w_tail_nxt  = NOP_ENTRY;
      w_count_nxt = 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            w_head_nxt = w_new;
          end else begin
            w_tail_nxt = w_new;
          end
          w_count_nxt = r_count + 2'd1;
        end
        2'b01: begin
          if (r_count == 2'd2) begin
            w_head_nxt = r_tail;
          end else begin
            w_head_nxt = r_head;
          end
          w_count_nxt = r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            w_head_nxt = w_new;
          end else begin
            w_head_nxt = r_tail;
            w_tail_nxt = w_new;
          end
        end
        default: begin
          w_count_nxt = r_count;
        end
      endcase
    end
  end

  // Buffer and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head      <= NOP_ENTRY;
      r_tail      <= NOP_ENTRY;
      r_count     <= 2'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_head      <= w_head_nxt;
      r_tail      <= w_tail_nxt;
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_count_nxt < 2'd2);
      r_out_valid <= (w_count_nxt != 2'd0);
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_pc       = r_head.pc;
  assign out_opcode   = r_head.dec.opcode;
  assign out_rs1      = r_head.dec.rs1;
  assign out_rs2      = r_head.dec.rs2;
  assign out_rd       = r_head.dec.rd;
  assign out_func     = r_head.dec.func;
  assign out_imm16    = r_head.dec.imm16;
  assign out_imm_zext = r_head.dec.imm_zext;
  assign out_imm26    = r_head.dec.imm26;
  assign out_type     = r_head.dec.itype;
  assign out_wr_en    = r_head.dec.wr_en;

endmodule

// File: tb/tb_dlx_ir_decode.sv
// Bench for dlx_ir_decode: queue-based reference of the stage plus directed
// vectors with literal expectations.
module tb_dlx_ir_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [5:0]  out_func;
  logic [15:0] out_imm16;
  logic        out_imm_zext;
  logic [25:0] out_imm26;
  logic [1:0]  out_type;
  logic        out_wr_en;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  item_t       q[$];
  logic [31:0] popped[$];
  bit          nop_exp = 1'b1;

  always #5 clk = ~clk;

  dlx_ir_decode dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .in_ready     (in_ready),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_opcode   (out_opcode),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2),
    .out_rd       (out_rd),
    .out_func     (out_func),
    .out_imm16    (out_imm16),
    .out_imm_zext (out_imm_zext),
    .out_imm26    (out_imm26),
    .out_type     (out_type),
    .out_wr_en    (out_wr_en)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_type(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    if (op == 6'h00) return 2'd0;
    else if (op == 6'h02 || op == 6'h03) return 2'd2;
    else if (op inside {6'h04, 6'h05, 6'h2B, [6'h08:6'h0F], 6'h23}) return 2'd1;
    else return 2'd3;
  endfunction

  function automatic logic [4:0] exp_rd(input logic [31:0] w);
    case (exp_type(w))
      2'd0:    return w[15:11];
      2'd1:    return w[20:16];
      2'd2:    return (w[31:26] == 6'h03) ? 5'd31 : 5'd0;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic exp_wr(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    if (op == 6'h03) return 1'b1;
    if (op == 6'h00 || op inside {[6'h08:6'h0F], 6'h23}) return exp_rd(w) != 5'd0;
    return 1'b0;
  endfunction

  // Reference stage: queue of accepted instructions, updated each rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      nop_exp = 1'b1;
    end else if (flush) begin
      q.delete();
      nop_exp = 1'b1;
    end else begin
      automatic bit do_pop  = (q.size() > 0) && out_ready;
      automatic bit do_push = in_valid && (q.size() < 2);
      if (do_pop) begin
        popped.push_back(q[0].pc);
        void'(q.pop_front());
      end
      if (do_push) begin
        q.push_back('{instr: in_instr, pc: in_pc});
        nop_exp = 1'b0;
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2)});
    if (q.size() > 0) begin
      automatic logic [31:0] w = q[0].instr;
      chk("out_valid", {31'd0, out_valid}, 32'd1);
      chk("pc", out_pc, q[0].pc);
      chk("opcode", {26'd0, out_opcode}, {26'd0, w[31:26]});
      chk("rs1", {27'd0, out_rs1}, {27'd0, w[25:21]});
      chk("rs2", {27'd0, out_rs2}, {27'd0, w[20:16]});
      chk("rd", {27'd0, out_rd}, {27'd0, exp_rd(w)});
      chk("func", {26'd0, out_func}, (exp_type(w) == 2'd0) ? {26'd0, w[5:0]} : 32'd0);
      chk("imm16", {16'd0, out_imm16}, {16'd0, w[15:0]});
      chk("imm_zext", {31'd0, out_imm_zext},
          {31'd0, (w[31:26] inside {6'h09, 6'h0B, 6'h0C, 6'h0D, 6'h0E})});
      chk("imm26", {6'd0, out_imm26}, {6'd0, w[25:0]});
      chk("type", {30'd0, out_type}, {30'd0, exp_type(w)});
      chk("wr_en", {31'd0, out_wr_en}, {31'd0, exp_wr(w)});
    end else begin
      chk("out_valid_idle", {31'd0, out_valid}, 32'd0);
      if (nop_exp) begin
        chk("nop_type", {30'd0, out_type}, 32'd0);
        chk("nop_wr_en", {31'd0, out_wr_en}, 32'd0);
        chk("nop_rd", {27'd0, out_rd}, 32'd0);
        chk("nop_pc", out_pc, 32'd0);
      end
    end
  end

  // Present a word from a falling edge until it is taken; returns on the
  // falling edge after the accepting rising edge.
  task automatic drive(input logic [31:0] w, input logic [31:0] pc);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_instr = w;
    in_pc    = pc;
    for (int n = 0; n < 20 && !done; n++) begin
      if (in_ready) done = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_type", {30'd0, out_type}, 32'd0);
    chk("rst_pc", out_pc, 32'd0);

    out_ready = 1'b1;
    drive(32'h2001_FFFF, 32'h0000_0100);
    chk("addi_valid", {31'd0, out_valid}, 32'd1);
    chk("addi_type", {30'd0, out_type}, 32'd1);
    chk("addi_rs1", {27'd0, out_rs1}, 32'd0);
    chk("addi_rd", {27'd0, out_rd}, 32'd1);
    chk("addi_imm16", {16'd0, out_imm16}, 32'h0000_FFFF);
    chk("addi_zext", {31'd0, out_imm_zext}, 32'd0);
    chk("addi_wr_en", {31'd0, out_wr_en}, 32'd1);

    drive(32'h3402_8000, 32'h0000_0104);
    chk("ori_zext", {31'd0, out_imm_zext}, 32'd1);
    chk("ori_imm16", {16'd0, out_imm16}, 32'h0000_8000);
    chk("ori_rd", {27'd0, out_rd}, 32'd2);
    @(negedge clk);

    // Stall with three back-to-back words.
    popped.delete();
    out_ready = 1'b0;
    drive(32'h2003_0001, 32'h0000_0200);
    drive(32'h2004_0002, 32'h0000_0204);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1; in_instr = 32'h2005_0003; in_pc = 32'h0000_0208;
    repeat (2) @(negedge clk);
    chk("held_in_ready", {31'd0, in_ready}, 32'd0);
    chk("held_head_pc", out_pc, 32'h0000_0200);
    out_ready = 1'b1;
    drive(32'h2005_0003, 32'h0000_0208);
    repeat (3) @(negedge clk);
    chk("order_count", popped.size(), 32'd3);
    if (popped.size() == 3) begin
      chk("order_0", popped[0], 32'h0000_0200);
      chk("order_1", popped[1], 32'h0000_0204);
      chk("order_2", popped[2], 32'h0000_0208);
    end

    drive(32'h0C00_0010, 32'h0000_0300);
    chk("jal_type", {30'd0, out_type}, 32'd2);
    chk("jal_rd", {27'd0, out_rd}, 32'd31);
    chk("jal_wr_en", {31'd0, out_wr_en}, 32'd1);
    chk("jal_imm26", {6'd0, out_imm26}, 32'h0000_0010);
    drive(32'h0000_0000, 32'h0000_0304);
    chk("nop_instr_type", {30'd0, out_type}, 32'd0);
    chk("nop_instr_wr_en", {31'd0, out_wr_en}, 32'd0);
    @(negedge clk);

    // Flush with a full buffer and a word on the input.
    out_ready = 1'b0;
    drive(32'h2006_0004, 32'h0000_0400);
    drive(32'h2007_0005, 32'h0000_0404);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h2008_0006; in_pc = 32'h0000_0408;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_type", {30'd0, out_type}, 32'd0);
    chk("flush_pc", out_pc, 32'd0);

    // Flush with one entry while the input has room: the word must be dropped.
    drive(32'h2009_0007, 32'h0000_0500);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h200A_0008; in_pc = 32'h0000_0504;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush1_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("flush1_dropped", {31'd0, out_valid}, 32'd0);

    // Illegal opcode, then asynchronous reset during the stall.
    drive(32'hFC00_0000, 32'h0000_0600);
    chk("ill_valid", {31'd0, out_valid}, 32'd1);
    chk("ill_type", {30'd0, out_type}, 32'd3);
    chk("ill_wr_en", {31'd0, out_wr_en}, 32'd0);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dlx_ir_decode.md
Name: dlx_ir_decode

Overview:
- DLX instruction-register and decode stage, directly upstream of the immediate extender.
- Accepts 32-bit instructions from fetch over a valid/ready handshake.
- Registers the instructions in a 2-entry skid buffer and splits them into register fields, a 16-bit immediate with an extension-select bit, and a 26-bit jump offset.
- Outputs drive the register file, the sign/zero extender and the ALU control.

Parameters:
- DEPTH, 2, skid buffer entries; only 2 is supported, elaboration-time check.
- NOP_INSTR, 32'h0000_0000, instruction substituted on flush and reset (R-type, func 0).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_instr  in  32  raw instruction word.
- in_pc  in  32  PC of in_instr.
- in_ready  out  1  stage can accept this cycle.
- flush  in  1  discard all buffered instructions (branch taken).
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  execute stage accepts.
- out_pc  out  32  PC of the decoded instruction.
- out_opcode  out  6  instr[31:26].
- out_rs1  out  5  instr[25:21].
- out_rs2  out  5  instr[20:16].
- out_rd  out  5  R-type instr[15:11]; I-type instr[20:16]; JAL 5'd31; otherwise 0.
- out_func  out  6  instr[5:0] for R-type, else 0.
- out_imm16  out  16  instr[15:0]; feeds the extender.
- out_imm_zext  out  1  1 selects zero extension, 0 selects sign extension.
- out_imm26  out  26  instr[25:0], valid for J/JAL.
- out_type  out  2  0 = R, 1 = I, 2 = J, 3 = illegal.
- out_wr_en  out  1  instruction writes the register file.

Behaviour:
- Reset:
  - out_valid = 0, in_ready = 1, buffer count = 0.
  - All decoded outputs hold the decode of NOP_INSTR: type R, wr_en 0, rd 0, pc 0.
  - Reset is asynchronous on assertion and is released synchronously to clk.
- Handshake:
  - A transfer occurs on a cycle where valid && ready, sampled at the rising edge.
  - in_ready = (count < 2). It is registered: it drops only in the cycle after the second entry is written.
  - Latency: an instruction accepted at edge N appears on the outputs after edge N, with out_valid = 1. There is no combinational path from in_* to out_*.
  - Head entry = outputs; tail entry = skid slot.
  - Push with no pop: count increments.
  - Pop with no push: the tail moves to the head and count decrements.
  - Simultaneous push and pop: count is unchanged, ordering is preserved.
  - With count = 2, in_ready = 0 and no push is possible.
- Decoded outputs are stable while out_valid && !out_ready.
- Flush:
  - Has priority over push and pop in the same cycle: count becomes 0, out_valid becomes 0, and the outputs revert to the NOP decode.
  - An in_valid presented in the flush cycle is dropped, not accepted.
  - in_ready = 1 on the next cycle.
- Decode:
  - Performed on entry write; registered fields are stored per entry.
  - opcode 6'h00 → R-type, wr_en = (rd != 0).
  - opcode 6'h02 (J), 6'h03 (JAL) → J-type; wr_en = 1 only for JAL, rd = 31.
  - opcode 6'h04, 6'h05 (BEQZ/BNEZ), 6'h2B (SW) → I-type, wr_en = 0.
  - opcode 6'h08–6'h0F, 6'h23 (LW) → I-type, wr_en = (rd != 0).
  - out_imm_zext = 1 for 6'h09 ADDUI, 6'h0B SUBUI, 6'h0C ANDI, 6'h0D ORI, 6'h0E XORI; 0 for all other opcodes.
  - Any other opcode → type 3 (illegal), wr_en 0. The instruction still flows through and is not dropped.
- Writes to r0 never assert wr_en.
- Reset mid-stream: all entries are lost, with no partial output.

Decomposition:
- Shared package dlx_pkg holds:
  - opcode localparams (OP_RTYPE, OP_J, OP_JAL, OP_BEQZ, OP_BNEZ, OP_ADDI … OP_LHI, OP_LW, OP_SW);
  - the instr_type enum (R/I/J/ILL);
  - the field bit-position constants;
  - a decoded-instruction struct type.
- Sub-module dlx_field_decode: purely combinational, instr → decoded struct. It is instantiated once at the buffer write port. The top level holds the skid buffer and handshake.

Test Plan:
- Reset, then push 32'h2001_FFFF (ADDI r1, r0, -1) with out_ready = 1 → next cycle: out_valid = 1, type I, rs1 0, rd 1, imm16 16'hFFFF, imm_zext 0, wr_en 1.
- Push 32'h3402_8000 (ORI r2, r0, 0x8000) → imm_zext 1, imm16 16'h8000, rd 2.
- out_ready = 0 with 3 back-to-back in_valid words A, B, C → A and B accepted, in_ready = 0 from the cycle after B is written, C held. Release out_ready → A, B, C emerge in order with no loss or duplication.
- Push 32'h0C00_0010 (JAL +16) → type J, rd 31, wr_en 1, imm26 26'h10. Then push 32'h0000_0000 (R-type with rd 0) → wr_en 0.
- count = 2 with flush and in_valid both high → next cycle: out_valid = 0, in_ready = 1, incoming word not accepted.
- Push opcode 6'h3F → type 3, wr_en 0, out_valid = 1. Assert rst_n = 0 mid-stall → out_valid drops immediately (asynchronously), without waiting for a clock edge.
